// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_prefetch_unit_pkg;

  localparam int PC_STEP = 4;

  // Occupancy/credit counters must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Show-ahead synchronous FIFO holding {pc, instruction} pairs; flush empties it in one cycle.
module fetch_prefetch_unit_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic [WIDTH-1:0]            head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset; readers qualify the head with a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: PC generation, req/gnt/rvalid credit tracking, redirect squash, prefetch FIFO.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int              CW        = cnt_width(DEPTH);
  localparam logic [CW:0]     DEPTH_EXT = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP      = XLEN'(PC_STEP);

  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    resp_pc;
  logic [XLEN-1:0]    target_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      discard;
  logic [CW-1:0]      count;
  logic [XLEN+31:0]   head_data;
  logic               handshake;
  logic               rsp_keep;
  logic               rsp_drop;
  logic               push;
  logic               pop;

  // Two credits: FIFO room for every live request, and a bound on all responses still owed.
  assign imem_req_o  = rst && !redirect_i
                       && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_EXT)
                       && (({1'b0, outstanding} + {1'b0, discard}) < DEPTH_EXT);
  assign imem_addr_o = fetch_pc;
  assign handshake   = imem_req_o && imem_gnt_i;

  // Squashed responses drain first; rvalid with nothing owed is ignored.
  assign rsp_drop  = imem_rvalid_i && (discard != '0);
  assign rsp_keep  = imem_rvalid_i && (discard == '0) && (outstanding != '0);
  assign push      = rsp_keep && !redirect_i;
  assign pop       = instr_valid_o && instr_ready_i && !redirect_i;
  assign target_pc = redirect_pc_i & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_i) begin
      // Every response still owed, minus the one arriving now, becomes a discard.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(rsp_drop) - CW'(rsp_keep);
    end else begin
      if (handshake) fetch_pc <= fetch_pc + STEP;
      if (rsp_keep)  resp_pc  <= resp_pc + STEP;
      outstanding <= outstanding + CW'(handshake) - CW'(rsp_keep);
      discard     <= discard - CW'(rsp_drop);
    end
  end

  fetch_prefetch_unit_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data ({resp_pc, imem_rdata_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .count     (count),
    .head_data (head_data)
  );

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? head_data[31:0] : '0;
  assign instr_pc_o    = instr_valid_o ? head_data[XLEN+31:32] : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed-then-random bench for fetch_prefetch_unit with an in-order variable-latency memory model.
module tb_fetch_prefetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        redirect, req, gnt, rvalid, instr_valid, ready;
  logic [31:0] redirect_pc, addr, rdata, instr, instr_pc;

  logic        w_redirect, w_req, w_gnt, w_rvalid, w_valid, w_ready;
  logic [31:0] w_redirect_pc, w_addr, w_rdata, w_instr, w_pc;

  fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata), .instr_valid_o(instr_valid), .instr_o(instr),
    .instr_pc_o(instr_pc), .instr_ready_i(ready)
  );

  fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst_n), .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid),
    .imem_rdata_i(w_rdata), .instr_valid_o(w_valid), .instr_o(w_instr),
    .instr_pc_o(w_pc), .instr_ready_i(w_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Memory model and expected instruction stream.
  int          cyc = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_q[$];
  int          p_gnt, p_ready, p_rvalid, p_redir, lat_max;
  bit          hold_rsp, redir_fixed;
  logic [31:0] redir_target;
  bit          prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;
  int          hs_cnt, pops;
  logic [31:0] last_hs_addr, last_pop_pc;
  bit          w_pend;
  logic [31:0] w_pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_inputs();
    gnt         = (int'($urandom_range(99)) < p_gnt);
    ready       = (int'($urandom_range(99)) < p_ready);
    redirect    = (p_redir > 0) && (int'($urandom_range(99)) < p_redir);
    redirect_pc = redir_fixed ? redir_target : $urandom;
    if (!hold_rsp && pend_addr.size() > 0 && pend_due[0] <= cyc
        && int'($urandom_range(99)) < p_rvalid) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_addr[0]);
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    w_gnt    = 1'b1;
    w_ready  = 1'b1;
    w_rvalid = w_pend;
    w_rdata  = ~w_pend_addr;
  endtask

  task automatic sample();
    logic [31:0] e;
    if (prev_redir) check("flush_empty", instr_valid, 1'b0);
    if (prev_req && !prev_gnt && !prev_redir && !redirect) begin
      check("req_hold", req, 1'b1);
      check("addr_hold", addr, prev_addr);
    end
    if (instr_valid && ready && !redirect) begin
      check("pop_pc", instr_pc, exp_pc);
      check("pop_data", instr, mem_word(exp_pc));
      last_pop_pc = instr_pc;
      exp_pc      = exp_pc + 32'd4;
      pops++;
    end
    if (rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (req && gnt) begin
      pend_addr.push_back(addr);
      pend_due.push_back(cyc + int'($urandom_range(lat_max, 1)));
      hs_cnt++;
      last_hs_addr = addr;
      check("inflight_bound", 32'(pend_addr.size() <= DEPTH), 32'd1);
    end
    if (redirect) exp_pc = redirect_pc & ~32'h3;
    if (w_valid && w_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("wrap_pc", w_pc, e);
      check("wrap_data", w_instr, ~e);
    end
    w_pend      = w_req && w_gnt;
    w_pend_addr = w_addr;
    prev_req    = req;
    prev_gnt    = gnt;
    prev_redir  = redirect;
    prev_addr   = addr;
    cyc++;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    drive_inputs();
    #1;
    sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect = 1'b0; redirect_pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    w_rvalid = 1'b0; w_rdata = '0; w_gnt = 1'b0; w_ready = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_pc = 32'h0;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    w_pend = 1'b0; w_pend_addr = '0;
    hs_cnt = 0; pops = 0; last_hs_addr = '0; last_pop_pc = '0;
    #1;
    check("rst_req", req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_mode(input int g, input int r, input int v, input int d, input int lm);
    p_gnt = g; p_ready = r; p_rvalid = v; p_redir = d; lat_max = lm;
    hold_rsp = 1'b0; redir_fixed = 1'b0;
  endtask

  initial begin
    w_redirect = 1'b0;
    w_redirect_pc = '0;
    redir_target = '0;
    set_mode(0, 0, 0, 0, 1);

    // Streaming with 1-cycle memory, then a redirect coinciding with pop and rvalid.
    do_reset();
    set_mode(100, 100, 100, 0, 1);
    repeat (10) run_cycle();
    pops = 0;
    repeat (10) run_cycle();
    check("steady_rate", pops, 10);
    redir_fixed = 1'b1; redir_target = 32'h200; p_redir = 100;
    run_cycle();
    p_redir = 0;
    repeat (10) run_cycle();

    // Decode stalled: exactly DEPTH requests, then resume at the next word.
    do_reset();
    set_mode(100, 0, 100, 0, 1);
    repeat (12) run_cycle();
    check("full_hs", hs_cnt, DEPTH);
    check("full_last_addr", last_hs_addr, 32'hC);
    check("full_req_low", req, 1'b0);
    p_ready = 100;
    for (int i = 0; i < 10 && hs_cnt <= DEPTH; i++) run_cycle();
    check("resume_addr", last_hs_addr, 32'h10);

    // Grant withheld: request and address stay put.
    do_reset();
    set_mode(0, 100, 100, 0, 1);
    repeat (5) begin
      run_cycle();
      check("stall_req", req, 1'b1);
      check("stall_addr", addr, 32'h0);
    end
    p_gnt = 100;
    run_cycle();
    run_cycle();
    check("post_gnt_addr", last_hs_addr, 32'h4);

    // Redirect with two responses still in flight; they must be dropped.
    do_reset();
    set_mode(100, 100, 100, 0, 1);
    hold_rsp = 1'b1;
    repeat (2) run_cycle();
    check("two_inflight", pend_addr.size(), 2);
    redir_fixed = 1'b1; redir_target = 32'h103; p_redir = 100;
    run_cycle();
    p_redir = 0; hold_rsp = 1'b0;
    pops = 0;
    for (int i = 0; i < 30 && pops == 0; i++) run_cycle();
    check("redir_first_pc", last_pop_pc, 32'h100);

    // Random traffic with random redirects and latencies.
    do_reset();
    set_mode(70, 60, 70, 4, 3);
    repeat (2000) run_cycle();
    check("random_progress", 32'(pops > 50), 32'd1);

    // PC wrap on the second instance, then asynchronous reset mid-burst.
    do_reset();
    set_mode(100, 100, 100, 0, 1);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    repeat (8) run_cycle();
    check("wrap_all_seen", exp_q.size(), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", req, 1'b0);
    check("async_valid", instr_valid, 1'b0);
    check("async_instr", instr, 32'h0);
    check("async_pc", instr_pc, 32'h0);
    check("async_w_req", w_req, 1'b0);
    check("async_w_valid", w_valid, 1'b0);
    check("async_w_pc", w_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
